// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-phase instruction sequencer wrapping an external combinational ALU
//
// Purpose:
//   Holds a 4x8 register file R0..R3. Each accepted instruction goes through
//   IDLE -> ISSUE -> WB. Operands are registered at accept. The external ALU
//   response is captured at the end of ISSUE. The result is committed at the
//   end of WB, when a one-cycle done pulse is also given.
//
// Optional feature (macro ALU_MULHIGH_WB_EN):
//   When defined, MULTIPLY also writes the high product byte into
//   R[(rd+1) mod 4]. When undefined, the high byte is dropped.
//
// Ports:
//   clk           in   1  rising-edge clock
//   reset         in   1  synchronous active-high reset
//   instr_valid   in   1  instruction offered
//   instr_ready   out  1  high only while IDLE
//   instr_op      in   4  ALU function select (1110 MULTIPLY, 1111 COMPARE)
//   instr_rd      in   2  destination register, also operand A index
//   instr_rs      in   2  operand B register index
//   ld_valid      in   1  direct register load strobe
//   ld_addr       in   2  load target register
//   ld_data       in   8  load value
//   alu_A         out  8  operand A to ALU (held until next accept)
//   alu_B         out  8  operand B to ALU (held until next accept)
//   alu_fsl       out  4  function select to ALU (held until next accept)
//   alu_result    in   8  ALU result
//   alu_mul_high  in   8  ALU multiply high byte
//   alu_SREG      in   4  ALU status {OVERFLOW,SIGN,CARRY,ZERO}
//   flags         out  4  latched status register
//   done          out  1  one-cycle completion pulse in WB
//   rf_addr       in   2  observation read address
//   rf_data       out  8  combinational register file read

module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [1:0] instr_rd,
  input  logic [1:0] instr_rs,
  input  logic       ld_valid,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  output logic [3:0] alu_fsl,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_mul_high,
  input  logic [3:0] alu_SREG,
  output logic [3:0] flags,
  output logic       done,
  input  logic [1:0] rf_addr,
  output logic [7:0] rf_data
);

  localparam logic [3:0] OP_MULTIPLY = 4'b1110;
  localparam logic [3:0] OP_COMPARE  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] regs [4];

  // Destination of the instruction in flight
  logic [1:0] rd_q;

  // ALU response captured at the end of ISSUE
  logic [7:0] result_q;
  logic [3:0] sreg_q;

`ifdef ALU_MULHIGH_WB_EN
  logic [7:0] mul_high_q;
`else
  // In this build the multiply high byte is deliberately discarded
  logic unused_mul_high;
  assign unused_mul_high = ^alu_mul_high;
`endif

  assign rf_data = regs[rf_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      alu_A       <= 8'h00;
      alu_B       <= 8'h00;
      alu_fsl     <= 4'h0;
      flags       <= 4'h0;
      rd_q        <= 2'd0;
      result_q    <= 8'h00;
      sreg_q      <= 4'h0;
`ifdef ALU_MULHIGH_WB_EN
      mul_high_q  <= 8'h00;
`endif
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      // The direct load is issued first so that a WB write to the same
      // register later in this block overrides it.
      if (ld_valid) begin
        regs[ld_addr] <= ld_data;
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (instr_valid) begin
            // Operands are read before this edge's load takes effect. They
            // then stay frozen, so later loads cannot disturb them.
            alu_A       <= regs[instr_rd];
            alu_B       <= regs[instr_rs];
            alu_fsl     <= instr_op;
            rd_q        <= instr_rd;
            instr_ready <= 1'b0;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          result_q <= alu_result;
          sreg_q   <= alu_SREG;
`ifdef ALU_MULHIGH_WB_EN
          mul_high_q <= alu_mul_high;
`endif
          done     <= 1'b1;
          state    <= S_WB;
        end

        S_WB: begin
          // alu_fsl still holds the accepted opcode here
          flags <= sreg_q;
          if (alu_fsl != OP_COMPARE) begin
            regs[rd_q] <= result_q;
          end
`ifdef ALU_MULHIGH_WB_EN
          if (alu_fsl == OP_MULTIPLY) begin
            regs[rd_q + 2'd1] <= mul_high_q;
          end
`endif
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
